// File: rtl/music_pkg.sv
// Shared pitch constants for the tone generator.
// Half-period table for octave 0 (C2..B2) in 100 MHz clock cycles.
package music_pkg;

   localparam int NOTES_PER_OCT = 12;
   localparam int OCT_MAX = 5;
   localparam int CNT_W = 20;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   // round(50e6 / f_n), with A2 = 110 Hz
   localparam logic [19:0] BASE_HP [NOTES_PER_OCT] = '{
      20'd764451, 20'd721546, 20'd681049, 20'd642824,
      20'd606745, 20'd572691, 20'd540549, 20'd510210,
      20'd481574, 20'd454545, 20'd429034, 20'd404954
   };

endpackage

// File: rtl/tone_gen_if.sv
// Note request handshake between the note divider and the tone generator.
interface tone_gen_if;

   logic       note_valid;
   logic [2:0] octave;
   logic [3:0] note;
   logic       note_ready;

   modport master (
      output note_valid,
      output octave,
      output note,
      input  note_ready
   );

   modport slave (
      input  note_valid,
      input  octave,
      input  note,
      output note_ready
   );

endinterface

// File: rtl/note_period_lut.sv
// Maps {octave, note} to a half-period count, or flags a rest.
module note_period_lut #(
   parameter int CNT_W = 20,
   parameter int OCT_MAX = 5
) (
   input  logic [2:0]       octave,
   input  logic [3:0]       note,
   output logic [CNT_W-1:0] hp,
   output logic             rest
);

   import music_pkg::*;

   logic [19:0] base;

   always_comb begin
      base = '0;
      if (note < 4'(NOTES_PER_OCT)) base = BASE_HP[note];
   end

   assign rest = (note >= 4'(NOTES_PER_OCT)) || (32'(octave) > OCT_MAX);
   assign hp = CNT_W'(base >> octave);

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator with a one-entry pending note slot.
// Pitch changes take effect only on a full-period boundary.
module tone_gen #(
   parameter int CNT_W = 20,
   parameter int OCT_MAX = 5
) (
   input  logic clk,
   input  logic rst_n,
   tone_gen_if.slave req,
   output logic spk_out,
   output logic active
);

   import music_pkg::*;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hp;
   logic             pend_valid;
   logic [2:0]       pend_oct;
   logic [3:0]       pend_note;
   logic [CNT_W-1:0] hp_new;
   logic             rest;
   logic             accept;

   assign req.note_ready = !pend_valid;
   assign accept = req.note_valid && !pend_valid;

   // The pending note is decoded when consumed, not when accepted
   note_period_lut #(
      .CNT_W(CNT_W),
      .OCT_MAX(OCT_MAX)
   ) u_lut (
      .octave(pend_oct),
      .note(pend_note),
      .hp(hp_new),
      .rest(rest)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         hp         <= '0;
         pend_valid <= 1'b0;
         pend_oct   <= '0;
         pend_note  <= '0;
         spk_out    <= 1'b0;
         active     <= 1'b0;
      end else begin
         if (accept) begin
            pend_valid <= 1'b1;
            pend_oct   <= req.octave;
            pend_note  <= req.note;
         end
         unique case (state)
            IDLE: begin
               if (pend_valid) begin
                  pend_valid <= 1'b0;
                  if (!rest) begin
                     hp      <= hp_new;
                     cnt     <= '0;
                     spk_out <= 1'b1;
                     active  <= 1'b1;
                     state   <= PLAY;
                  end
               end
            end
            PLAY: begin
               if (cnt == hp - 1'b1) begin
                  cnt <= '0;
                  if (spk_out) begin
                     spk_out <= 1'b0;
                  end else if (!pend_valid) begin
                     spk_out <= 1'b1;
                  end else begin
                     pend_valid <= 1'b0;
                     if (rest) begin
                        active <= 1'b0;
                        state  <= IDLE;
                     end else begin
                        hp      <= hp_new;
                        spk_out <= 1'b1;
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
